// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded field bundles into 16-bit instruction
// words and hands them, with their byte addresses, to an instruction memory
// writer through a one-deep valid/ready output register.
module instr_encoder #(
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter bit          STOP_ON_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  opcode,
  input  logic [2:0]  rs,
  input  logic [2:0]  rt,
  input  logic [2:0]  rd,
  input  logic [10:0] imm,
  input  logic [1:0]  funct,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [15:0] out_addr,
  output logic [15:0] instr_count,
  output logic        err_illegal,
  output logic        done
);

  typedef enum logic [1:0] {RUN, HALTWAIT, DONE} state_e;

  localparam logic [4:0] OP_HALT = 5'b00000;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;

  logic [15:0] enc_word;
  logic        illegal;
  logic        accept;
  logic        emit;

  // Format selection: map the opcode onto its field packing.
  always_comb begin
    enc_word = '0;
    illegal  = 1'b0;
    case (opcode)
      5'b00000, 5'b00001:
        enc_word = {opcode, 11'b0};
      5'b00010, 5'b00011:
        illegal = 1'b1;
      5'b00100, 5'b00110:
        enc_word = {opcode, imm};
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111,
      5'b10000, 5'b10001, 5'b10011:
        enc_word = {opcode, rs, rd, imm[4:0]};
      5'b11000, 5'b10010, 5'b00101, 5'b00111,
      5'b01100, 5'b01101, 5'b01110, 5'b01111:
        enc_word = {opcode, rs, imm[7:0]};
      5'b11001:
        enc_word = {opcode, rs, 3'b000, rd, 2'b00};
      default:
        enc_word = {opcode, rs, rt, rd, funct};
    endcase
  end

  // FSM outputs: the input side is open only while running and the output
  // register is empty or draining this cycle.
  always_comb begin
    in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    done     = (state_q == DONE);
  end

  assign accept = in_valid && in_ready;
  assign emit   = out_valid_q && out_ready;

  // FSM next state: a HALT parks the encoder until its word is consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (accept && (opcode == OP_HALT) && STOP_ON_HALT) state_d = HALTWAIT;
      HALTWAIT: if (emit) state_d = DONE;
      DONE:     state_d = DONE;
      default:  state_d = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Datapath next state: capture on accept, drain on emit; both may occur in
  // the same cycle, in which case the captured word replaces the drained one.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    if (emit) begin
      out_valid_d = 1'b0;
      addr_d      = addr_q + 16'd2;
      if (count_q != '1) count_d = count_q + 16'd1;
    end
    if (accept) begin
      if (illegal) begin
        err_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = enc_word;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      addr_q      <= BASE_ADDR;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_addr    = addr_q;
  assign instr_count = count_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: two instances (default parameters, and
// BASE_ADDR=FFFE with STOP_ON_HALT=0) share one stimulus stream and are
// compared every cycle against a behavioural model, plus directed scenarios.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [4:0]  opcode;
  logic [2:0]  rs, rt, rd;
  logic [10:0] imm;
  logic [1:0]  funct;

  logic [1:0]  in_ready_w;
  logic [1:0]  out_valid_w;
  logic [1:0]  err_w;
  logic [1:0]  done_w;
  logic [15:0] out_data_w [2];
  logic [15:0] out_addr_w [2];
  logic [15:0] count_w    [2];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(16'h0000), .STOP_ON_HALT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .funct(funct),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
    .out_addr(out_addr_w[0]), .instr_count(count_w[0]), .err_illegal(err_w[0]),
    .done(done_w[0])
  );

  instr_encoder #(.BASE_ADDR(16'hFFFE), .STOP_ON_HALT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .funct(funct),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
    .out_addr(out_addr_w[1]), .instr_count(count_w[1]), .err_illegal(err_w[1]),
    .done(done_w[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model state, one slot per instance.
  logic [15:0] m_base [2] = '{16'h0000, 16'hFFFE};
  bit          m_stop [2] = '{1'b1, 1'b0};
  bit          m_init = 1'b0;
  bit          m_hv   [2];
  int unsigned m_word [2];
  int unsigned m_addr [2];
  int unsigned m_cnt  [2];
  bit          m_err  [2];
  int          m_ph   [2];   // 0 running, 1 waiting for HALT drain, 2 done

  // Encoding straight from the format tables, as field weights.
  function automatic int unsigned model_word(int unsigned op, int unsigned s, int unsigned t,
                                             int unsigned d, int unsigned im, int unsigned fn);
    int unsigned base;
    base = op * 2048;
    if (op <= 1) return base;
    if (op == 4 || op == 6) return base + (im % 2048);
    if ((op >= 8 && op <= 11) || (op >= 20 && op <= 23) || op == 16 || op == 17 || op == 19)
      return base + s * 256 + d * 32 + (im % 32);
    if (op == 25) return base + s * 256 + d * 4;
    if (op >= 26) return base + s * 256 + t * 32 + d * 4 + fn;
    return base + s * 256 + (im % 256);
  endfunction

  // One clock cycle: drive, check in_ready, clock, advance model, check outputs.
  task automatic step(input bit r, input bit iv, input bit ordy, input logic [4:0] op,
                      input logic [2:0] s, input logic [2:0] t, input logic [2:0] d,
                      input logic [10:0] im, input logic [1:0] fn);
    bit rdy [2];
    rst = r; in_valid = iv; out_ready = ordy;
    opcode = op; rs = s; rt = t; rd = d; imm = im; funct = fn;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy[k] = (m_ph[k] == 0) && (!m_hv[k] || ordy);
      if (m_init) check_eq($sformatf("d%0d in_ready", k), {31'b0, in_ready_w[k]}, {31'b0, rdy[k]});
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_hv[k] = 0; m_word[k] = 0; m_addr[k] = m_base[k]; m_cnt[k] = 0; m_err[k] = 0; m_ph[k] = 0;
      end else begin
        if (m_hv[k] && ordy) begin
          m_hv[k] = 0;
          m_addr[k] = (m_addr[k] + 2) % 65536;
          if (m_cnt[k] < 65535) m_cnt[k]++;
          if (m_ph[k] == 1) m_ph[k] = 2;
        end
        if (iv && rdy[k]) begin
          if (op == 2 || op == 3) m_err[k] = 1;
          else begin
            m_hv[k] = 1;
            m_word[k] = model_word(op, s, t, d, im, fn);
            if (op == 0 && m_stop[k]) m_ph[k] = 1;
          end
        end
      end
    end
    if (r) m_init = 1'b1;
    #1;
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        check_eq($sformatf("d%0d out_valid", k), {31'b0, out_valid_w[k]}, {31'b0, m_hv[k]});
        if (m_hv[k]) check_eq($sformatf("d%0d out_data", k), {16'b0, out_data_w[k]}, m_word[k]);
        check_eq($sformatf("d%0d out_addr", k), {16'b0, out_addr_w[k]}, m_addr[k]);
        check_eq($sformatf("d%0d instr_count", k), {16'b0, count_w[k]}, m_cnt[k]);
        check_eq($sformatf("d%0d err_illegal", k), {31'b0, err_w[k]}, {31'b0, m_err[k]});
        check_eq($sformatf("d%0d done", k), {31'b0, done_w[k]}, {31'b0, (m_ph[k] == 2)});
      end
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 5'd1, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, ordy, 5'd1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; rs = '0; rt = '0; rd = '0; imm = '0; funct = '0;
    @(posedge clk); #1;

    // Reset values
    do_reset();
    check_eq("rst out_data", {16'b0, out_data_w[0]}, 32'h0000);
    check_eq("rst out_addr", {16'b0, out_addr_w[0]}, 32'h0000);
    check_eq("rst in_ready", {31'b0, in_ready_w[0]}, 32'd1);

    // ADDI rs=2 rd=3 imm=7FF
    step(0, 1, 1, 5'b01000, 3'd2, 3'd0, 3'd3, 11'h7FF, 2'd0);
    check_eq("addi data", {16'b0, out_data_w[0]}, 32'h427F);
    check_eq("addi addr", {16'b0, out_addr_w[0]}, 32'h0000);
    idle(1);
    check_eq("addi count", {16'b0, count_w[0]}, 32'd1);

    // Back-to-back ADD, LBI, J
    do_reset();
    step(0, 1, 1, 5'b11011, 3'd1, 3'd2, 3'd3, 11'h000, 2'd0);
    check_eq("add data", {16'b0, out_data_w[0]}, 32'hD94C);
    check_eq("add addr", {16'b0, out_addr_w[0]}, 32'h0000);
    step(0, 1, 1, 5'b11000, 3'd5, 3'd0, 3'd0, 11'h0A5, 2'd0);
    check_eq("lbi data", {16'b0, out_data_w[0]}, 32'hC5A5);
    check_eq("lbi addr", {16'b0, out_addr_w[0]}, 32'h0002);
    step(0, 1, 1, 5'b00100, 3'd0, 3'd0, 3'd0, 11'h7FF, 2'd0);
    check_eq("j data", {16'b0, out_data_w[0]}, 32'h27FF);
    check_eq("j addr", {16'b0, out_addr_w[0]}, 32'h0004);
    idle(1);
    check_eq("b2b count", {16'b0, count_w[0]}, 32'd3);

    // Back-pressure, then drain and capture together
    do_reset();
    step(0, 1, 0, 5'b00001, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 5'b01000, 3'd2, 3'd0, 3'd3, 11'h7FF, 2'd0);
      check_eq("stall in_ready", {31'b0, in_ready_w[0]}, 32'd0);
      check_eq("stall data", {16'b0, out_data_w[0]}, 32'h0800);
    end
    step(0, 1, 1, 5'b01000, 3'd2, 3'd0, 3'd3, 11'h7FF, 2'd0);
    check_eq("release data", {16'b0, out_data_w[0]}, 32'h427F);
    check_eq("release addr", {16'b0, out_addr_w[0]}, 32'h0002);
    check_eq("release count", {16'b0, count_w[0]}, 32'd1);

    // Illegal opcode between two NOPs
    do_reset();
    step(0, 1, 1, 5'b00001, 0, 0, 0, 0, 0);
    check_eq("nop1 addr", {16'b0, out_addr_w[0]}, 32'h0000);
    step(0, 1, 1, 5'b00010, 0, 0, 0, 0, 0);
    check_eq("illegal valid", {31'b0, out_valid_w[0]}, 32'd0);
    check_eq("illegal err", {31'b0, err_w[0]}, 32'd1);
    step(0, 1, 1, 5'b00001, 0, 0, 0, 0, 0);
    check_eq("nop2 data", {16'b0, out_data_w[0]}, 32'h0800);
    check_eq("nop2 addr", {16'b0, out_addr_w[0]}, 32'h0002);
    idle(1);
    check_eq("illegal count", {16'b0, count_w[0]}, 32'd2);

    // HALT stops the default instance; the other keeps running
    do_reset();
    step(0, 1, 0, 5'b00000, 0, 0, 0, 0, 0);
    check_eq("halt data", {16'b0, out_data_w[0]}, 32'h0000);
    check_eq("halt in_ready", {31'b0, in_ready_w[0]}, 32'd0);
    check_eq("halt pending done", {31'b0, done_w[0]}, 32'd0);
    idle(1);
    check_eq("halt done", {31'b0, done_w[0]}, 32'd1);
    check_eq("nohalt done", {31'b0, done_w[1]}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 5'b00001, 0, 0, 0, 0, 0);
    check_eq("halt count", {16'b0, count_w[0]}, 32'd1);
    do_reset();
    check_eq("post-halt done", {31'b0, done_w[0]}, 32'd0);
    check_eq("post-halt count", {16'b0, count_w[0]}, 32'd0);
    check_eq("post-halt in_ready", {31'b0, in_ready_w[0]}, 32'd1);

    // Address wrap on the FFFE-based instance
    do_reset();
    step(0, 1, 1, 5'b00001, 0, 0, 0, 0, 0);
    check_eq("wrap addr0", {16'b0, out_addr_w[1]}, 32'hFFFE);
    step(0, 1, 1, 5'b00001, 0, 0, 0, 0, 0);
    check_eq("wrap addr1", {16'b0, out_addr_w[1]}, 32'h0000);

    // Randomized traffic with occasional mid-stream resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           5'($urandom_range(0, 31)), 3'($urandom), 3'($urandom), 3'($urandom),
           11'($urandom), 2'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000, byte address of the first emitted instruction word.
REQ-002 Parameter STOP_ON_HALT, default 1; when 1, encoding stops after a HALT word is emitted.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  field bundle on opcode/rs/rt/rd/imm/funct is valid.
REQ-006 in_ready  output  1  encoder accepts a bundle this cycle.
REQ-007 opcode  input  5  instruction opcode.
REQ-008 rs, rt, rd  input  3 each  register specifiers.
REQ-009 imm  input  11  immediate/displacement; only low bits used per format.
REQ-010 funct  input  2  R-format function field.
REQ-011 out_valid  output  1  out_data/out_addr hold an encoded word.
REQ-012 out_ready  input  1  downstream (instruction memory writer) consumes the word.
REQ-013 out_data  output  16  encoded instruction.
REQ-014 out_addr  output  16  byte address of out_data.
REQ-015 instr_count  output  16  number of words consumed downstream since reset.
REQ-016 err_illegal  output  1  sticky; an unmapped opcode was accepted.
REQ-017 done  output  1  HALT word consumed while STOP_ON_HALT=1.

Function
REQ-018 Accept (input handshake) when in_valid && in_ready; emit (output handshake) when out_valid && out_ready.
REQ-019 in_ready = (state == RUN) && (!out_valid || out_ready); a new word is captured in the same cycle the held one drains.
REQ-020 Latency: bundle accepted at edge N gives out_valid=1 with its encoding from after edge N; no combinational path from in_* to out_*.
REQ-021 Format 0: HALT 00000 and NOP 00001 encode as {opcode, 11'b0}; J 00100 and JAL 00110 encode as {opcode, imm[10:0]}.
REQ-022 Format 1: ADDI, SUBI, XORI, ANDNI (01000-01011), ROLI, SLLI, RORI, SRLI (10100-10111), ST 10000, LD 10001, STU 10011 encode as {opcode, rs, rd, imm[4:0]}.
REQ-023 Format 2: LBI 11000, SLBI 10010, JR 00101, JALR 00111, BEQZ, BNEZ, BLTZ, BGEZ (01100-01111) encode as {opcode, rs, imm[7:0]}.
REQ-024 Format 3: BTR 11001, 11010, 11011, SEQ 11100, SLT 11101, SLE 11110, SCO 11111 encode as {opcode, rs, rt, rd, funct}; BTR forces rt and funct fields to 0.
REQ-025 Unused high imm bits are truncated without error.
REQ-026 Opcodes 00010 and 00011 are illegal: the bundle is accepted, no word is emitted, out_valid and the address do not change, err_illegal sets.
REQ-027 Address register starts at BASE_ADDR, out_addr is the address of the held word, and it advances by 2 on every output handshake; 16'hFFFE wraps to 16'h0000.
REQ-028 instr_count increments by 1 on every output handshake and saturates at 16'hFFFF.
REQ-029 FSM states: RUN, HALTWAIT, DONE.
REQ-030 RUN -> HALTWAIT when a HALT is accepted and STOP_ON_HALT=1; HALTWAIT -> DONE on that HALT's output handshake; DONE holds until rst.
REQ-031 In HALTWAIT and DONE, in_ready=0; done=1 only in DONE.
REQ-032 When STOP_ON_HALT=0, HALT is encoded like NOP and the FSM stays in RUN.
REQ-033 Held out_data/out_addr remain stable while out_valid && !out_ready.

Reset
REQ-034 On rst: state=RUN, out_valid=0, out_data=0, out_addr=BASE_ADDR, instr_count=0, err_illegal=0, done=0; in_ready=1 on the first cycle after reset.
REQ-035 rst mid-operation discards any held word and any HALTWAIT/DONE condition; rst has priority over simultaneous handshakes.

Verification
REQ-036 ADDI rs=2 rd=3 imm=11'h7FF, out_ready=1 -> out_data=16'h427F, out_addr=16'h0000 one cycle later; instr_count=1.
REQ-037 Back-to-back ADD (11011, rs=1, rt=2, rd=3, funct=0), then LBI rs=5 imm=8'hA5, then J imm=11'h7FF, out_ready=1 -> 16'hD94C@0x0000, 16'hC5A5@0x0002, 16'h27FF@0x0004, one word per cycle.
REQ-038 Hold out_ready=0 for 3 cycles with a word held -> in_ready=0, out_data stable; release -> drain and capture in the same cycle.
REQ-039 opcode 00010 between two NOPs -> err_illegal=1, only two words 16'h0800 at 0x0000/0x0002, instr_count=2.
REQ-040 HALT with STOP_ON_HALT=1 -> 16'h0000 emitted, in_ready=0 afterward, done=1 after the output handshake; rst -> all REQ-034 values.
REQ-041 BASE_ADDR=16'hFFFE, two NOPs -> out_addr 16'hFFFE then 16'h0000.
